// File: rtl/parallel_serial.sv
// Parallel-to-serial converter with a one-word holding register and framing strobes.
// Words stream back-to-back with no idle bit when the next word is held before the current word's last bit.
module parallel_serial #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clk_en_i,
  input  logic                  parallel_valid_i,
  output logic                  parallel_ready_o,
  input  logic [WORD_WIDTH-1:0] parallel_i,
  output logic                  serial_o,
  output logic                  serial_valid_o,
  output logic                  last_o,
  output logic                  busy_o
);

  localparam int unsigned    CW       = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WORD_WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   hold_q;
  logic                    hold_full_q;
  logic [WORD_WIDTH-1:0]   shift_q, shift_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    accept;
  logic                    load;
  logic                    at_last;

  assign at_last          = (cnt_q == CNT_LAST);
  assign parallel_ready_o = clk_en_i & ~hold_full_q;
  assign accept           = parallel_valid_i & parallel_ready_o;
  // Accept needs an empty hold and load needs a full one, so they never touch the same entry.
  assign load             = hold_full_q & ((state_q == IDLE) | at_last);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          shift_d = hold_q;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (load) begin
          shift_d = hold_q;
          cnt_d   = '0;
        end else if (at_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (MSB_FIRST) shift_d = {shift_q[WORD_WIDTH-2:0], 1'b0};
          else           shift_d = {1'b0, shift_q[WORD_WIDTH-1:1]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      if (accept) begin
        hold_q      <= parallel_i;
        hold_full_q <= 1'b1;
      end else if (load) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign serial_valid_o = (state_q == SHIFT);
  assign serial_o       = serial_valid_o & (MSB_FIRST ? shift_q[WORD_WIDTH-1] : shift_q[0]);
  assign last_o         = serial_valid_o & at_last;
  assign busy_o         = serial_valid_o | hold_full_q;

endmodule

// File: doc/parallel_serial.md
# parallel_serial

Parallel-to-serial converter: accepts WORD_WIDTH-bit words on a valid/ready interface and shifts them out one bit per enabled clock on a single serial line, with framing strobes. It is the transmit counterpart of serial_parallel in the dw_adapter library and pairs with it for loopback. A one-word holding register allows back-to-back words to stream with no idle bit between them.

## Interface
- WORD_WIDTH, 8, bits per word; must be at least 2.
- MSB_FIRST, 1, 1 = bit WORD_WIDTH-1 is sent first; 0 = bit 0 is sent first.

- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  reset, asynchronous and active-low.
- clk_en_i  input  1  clock enable; when low, all state is frozen.
- parallel_valid_i  input  1  the word on parallel_i is offered.
- parallel_ready_o  output  1  a word can be accepted; combinational, equals clk_en_i & ~hold_full.
- parallel_i  input  WORD_WIDTH  word to serialise.
- serial_o  output  1  current serial bit; 0 when serial_valid_o is low.
- serial_valid_o  output  1  serial_o carries a data bit this cycle.
- last_o  output  1  serial_o carries the final bit of a word.
- busy_o  output  1  serial_valid_o | hold_full.

## Operation
- State:
  - hold register plus hold_full flag;
  - shift register;
  - bit counter, width $clog2(WORD_WIDTH), counting 0..WORD_WIDTH-1;
  - FSM with two states: IDLE and SHIFT.
- Accept: when parallel_valid_i & parallel_ready_o is high at a rising edge, parallel_i is written to hold and hold_full is set.
  - When clk_en_i is low, parallel_ready_o is 0, so no transfer can occur.
- Load: the shifter loads from hold and clears hold_full, and the counter resets to 0, when both hold:
  - hold_full = 1, and
  - the FSM is in IDLE, or it is in SHIFT with the counter at WORD_WIDTH-1.
- There is no bypass: a word always passes through hold. Because hold_full forces ready low, an accept and a load can never act on the same hold entry in the same edge.
- FSM transitions:
  - IDLE -> SHIFT on load.
  - SHIFT stays in SHIFT while the counter is below WORD_WIDTH-1 (counter increments, shifter advances one bit).
  - At counter = WORD_WIDTH-1: reload if hold_full, otherwise go to IDLE.
- Outputs:
  - serial_o is the MSB of the shifter when MSB_FIRST=1, otherwise the LSB.
  - serial_valid_o = (state == SHIFT).
  - last_o = serial_valid_o & (counter == WORD_WIDTH-1).
- All registers, including the counter and FSM state, update only when clk_en_i is high. With clk_en_i low, every output holds its value, except parallel_ready_o, which drops to 0.

## Timing
- Reset (asynchronous, effective immediately):
  - FSM = IDLE, hold_full = 0, counter = 0, shifter = 0, hold = 0.
  - serial_o = 0, serial_valid_o = 0, last_o = 0, busy_o = 0.
  - parallel_ready_o = clk_en_i.
- Latency: for a word accepted at enabled edge N when the block is idle:
  - the shifter loads at edge N+1;
  - the first bit is valid after edge N+1;
  - the last bit (with last_o) is valid after edge N+WORD_WIDTH.
- parallel_ready_o behaviour:
  - low from the accept edge until the edge that loads the word into the shifter;
  - in steady streaming, that load is the edge that ends the previous word's last bit.
- Throughput: one word per WORD_WIDTH enabled cycles. If the next word is held by the time last_o is high, there is zero gap between words.
- Reset asserted mid-word: the partial word and any held word are discarded. No bits are emitted after reset releases until a new accept occurs.
- clk_en_i toggling mid-word: the bit sequence is stretched, never corrupted or skipped. Each bit is presented for exactly one enabled cycle.

## Test plan
- Single word, WORD_WIDTH=8, MSB_FIRST=1, parallel_i=8'hA5:
  - serial_o on 8 consecutive valid cycles = 1,0,1,0,0,1,0,1;
  - last_o high only on the 8th bit;
  - first bit valid on the cycle after the edge following acceptance;
  - afterwards serial_valid_o=0 and serial_o=0.
- Back-to-back 8'hA5 then 8'h3C, valid held high:
  - 16 contiguous valid bits 10100101 00111100;
  - last_o high on bits 8 and 16;
  - parallel_ready_o low between each accept and its load.
- MSB_FIRST=0, parallel_i=8'h01: serial_o = 1,0,0,0,0,0,0,0.
- clk_en_i low for 3 cycles after bit 3 of 8'hA5:
  - serial_o frozen at bit 3's value (0) and parallel_ready_o=0 during the stall;
  - the remaining bits 0,1,0,1 then follow unchanged.
- rst_ni pulsed low after bit 4 of 8'hFF with 8'h00 held:
  - all outputs 0 immediately;
  - busy_o=0 and no bits appear after release until a new word 8'h81 is sent, which is emitted as 1,0,0,0,0,0,0,1.
- Loopback into serial_parallel (WORD_WIDTH=8) with random words and random clk_en_i gaps: every received word equals the word sent, in order.
